pipe_adder: RTL
===============

Name: pipe_adder

Overview:
- Parametrised, pipelined add/subtract unit; next-generation replacement for the single-bit combinational full adder.
- Splits a WIDTH-bit carry chain into STAGES registered segments and carries a valid/ready handshake on both sides.
- Reports sum, carry-out and signed overflow.
- Sits between a producer and a consumer in the datapath; throughput is one operation per cycle when not stalled.

Parameters:
- WIDTH, 8, operand and sum width in bits. Must be ≥ 2.
- STAGES, 2, number of pipeline register stages, which is also the latency. Must be ≥ 1 and must divide WIDTH exactly. Elaboration error otherwise.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  a/b/cin/sub are valid this cycle.
- in_ready  output  1  unit accepts the input this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in. Ignored when sub=1.
- sub  input  1  0: a+b+cin; 1: a−b, computed as a+~b+1.
- out_valid  output  1  result fields are valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- carry  output  1  carry-out of the MSB. In subtract mode 1 means no borrow.
- overflow  output  1  signed overflow: operand MSBs (after B inversion) are equal and the sum MSB differs.

Behaviour:
- Reset (async, any time, including mid-operation):
  - all stage-valid bits, sum, carry and overflow go to 0; out_valid=0.
  - In-flight operations are discarded. in_ready=1 from the first cycle after rst deasserts.
- Segmentation:
  - SEG = WIDTH/STAGES.
  - Stage k (0..STAGES−1) adds bits [k*SEG +: SEG] of A and B' (B' = sub ? ~b : b) plus the carry registered by stage k−1.
  - Stage 0's carry-in is sub ? 1 : cin.
  - Unprocessed upper operand segments and completed lower sum segments are skewed through stage registers alongside.
- Pipeline advance: advance = !out_valid || out_ready.
  - in_ready = advance (combinational).
  - On advance, every stage shifts forward one position.
  - Stage 0 loads valid = in_valid & in_ready.
  - Bubbles are not compressed.
- Latency: an input accepted at edge N appears with out_valid=1 after edge N+STAGES−1, i.e. visible in the cycle following edge N+STAGES−1 (STAGES cycles), provided out_ready stays high.
- Stall: while out_valid=1 and out_ready=0:
  - sum/carry/overflow/out_valid are held stable.
  - in_ready=0; no stage updates.
- Simultaneous in handshake and out handshake in one cycle: both occur, and the pipeline stays full at 1/cycle.
- Final stage sets carry = carry out of the top segment and overflow = (A[W−1]==B'[W−1]) && (sum[W−1]!=A[W−1]). These are registered with sum.
- Output fields when out_valid=0 hold their last values; consumers ignore them.
- STAGES=1 degenerates to a single registered full-width adder with latency 1.
- No combinational path from a/b/cin/sub to any output. The only combinational path is out_ready → in_ready.

Test Plan (WIDTH=8, STAGES=2 unless noted):
- 8'hFF + 8'h01, cin=0, sub=0, out_ready=1 → after 2 cycles: sum=8'h00, carry=1, overflow=0, out_valid=1 for one cycle.
- 8'h7F + 8'h01, cin=1 → sum=8'h81, carry=0, overflow=1. Also 8'h3C + 8'h0F, cin=1 → sum=8'h4C, carry=0, overflow=0.
- sub=1: 8'h05 − 8'h07 → sum=8'hFE, carry=0, overflow=0. Then 8'h80 − 8'h01 → sum=8'h7F, carry=1, overflow=1. Issue these back-to-back; results arrive on consecutive cycles.
- Back-pressure: stream 4 ops with in_valid=1 and hold out_ready=0 from the cycle the first result appears:
  - outputs hold the first result; in_ready=0 once the pipeline is full.
  - Release out_ready: all 4 results emerge in order, none lost or duplicated.
- Reset mid-flight: accept 2 ops, assert rst asynchronously between edges → out_valid=0 immediately. After deassert, no stale result ever appears. A new op 8'h10+8'h20 yields 8'h30 after 2 cycles.
- Parameter sweep: WIDTH=16, STAGES=4 and WIDTH=8, STAGES=1. Check 1000 random ops with random valid/ready against a reference a+b+cin / a−b model: latency equals STAGES when unstalled, and all fields match.

Source files
------------

// File: rtl/pipe_adder.sv
// Pipelined add/subtract unit: the WIDTH-bit carry chain is cut into STAGES
// registered segments, with a valid/ready handshake on both sides.
module pipe_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);
    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("pipe_adder: WIDTH must be >= 2 and an exact multiple of STAGES >= 1");
    end

    // Each stage carries the full operands and the partially built sum; stage k
    // fills in sum segment k and passes its segment carry to stage k+1.
    logic [STAGES-1:0]            v_q, v_d;
    logic [STAGES-1:0]            c_q, c_d;
    logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
    logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
    logic [STAGES-1:0][WIDTH-1:0] s_q, s_d;
    logic                         ov_q, ov_d;
    logic                         advance;

    assign advance = !v_q[LAST] || out_ready;

    always_comb begin
        logic [WIDTH-1:0] a_src;
        logic [WIDTH-1:0] b_src;
        logic [WIDTH-1:0] s_src;
        logic             c_src;
        logic             v_src;
        logic [SEG:0]     seg;
        v_d = '0;
        c_d = '0;
        a_d = '0;
        b_d = '0;
        s_d = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                a_src = a;
                b_src = sub ? ~b : b;
                s_src = '0;
                c_src = sub ? 1'b1 : cin;
                v_src = in_valid;
            end else begin
                a_src = a_q[k-1];
                b_src = b_q[k-1];
                s_src = s_q[k-1];
                c_src = c_q[k-1];
                v_src = v_q[k-1];
            end
            seg = {1'b0, a_src[k*SEG +: SEG]} + {1'b0, b_src[k*SEG +: SEG]}
                + {{SEG{1'b0}}, c_src};
            a_d[k]              = a_src;
            b_d[k]              = b_src;
            s_d[k]              = s_src;
            s_d[k][k*SEG +: SEG] = seg[SEG-1:0];
            c_d[k]              = seg[SEG];
            v_d[k]              = v_src;
        end
        ov_d = (a_d[LAST][WIDTH-1] == b_d[LAST][WIDTH-1])
            && (s_d[LAST][WIDTH-1] != a_d[LAST][WIDTH-1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q  <= '0;
            c_q  <= '0;
            a_q  <= '0;
            b_q  <= '0;
            s_q  <= '0;
            ov_q <= 1'b0;
        end else if (advance) begin
            v_q  <= v_d;
            c_q  <= c_d;
            a_q  <= a_d;
            b_q  <= b_d;
            s_q  <= s_d;
            ov_q <= ov_d;
        end
    end

    assign in_ready  = advance;
    assign out_valid = v_q[LAST];
    assign sum       = s_q[LAST];
    assign carry     = c_q[LAST];
    assign overflow  = ov_q;

endmodule
